// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the
// stall/flush controller: hazard sources in, stage controls out.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             RegWEn_e;
    logic             is_load_e;
    logic [4:0]       AddrD_e;
    logic [4:0]       AddrA_d;
    logic [4:0]       AddrB_d;
    logic             useA_d;
    logic             useB_d;
    logic             br_taken_e;
    logic             mem_req_m;
    logic             mem_ready_i;
    logic             hold_pc_o;
    logic             hold_fd_o;
    logic             hold_de_o;
    logic             hold_em_o;
    logic             flush_fd_o;
    logic             flush_de_o;
    logic             flush_mw_o;
    logic [1:0]       state_o;
    logic             mem_err_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output RegWEn_e, is_load_e, AddrD_e,
        output AddrA_d, AddrB_d, useA_d, useB_d,
        output br_taken_e, mem_req_m, mem_ready_i,
        input  hold_pc_o, hold_fd_o, hold_de_o,
        input  hold_em_o, flush_fd_o, flush_de_o,
        input  flush_mw_o, state_o, mem_err_o,
        input  stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  RegWEn_e, is_load_e, AddrD_e,
        input  AddrA_d, AddrB_d, useA_d, useB_d,
        input  br_taken_e, mem_req_m, mem_ready_i,
        output hold_pc_o, hold_fd_o, hold_de_o,
        output hold_em_o, flush_fd_o, flush_de_o,
        output flush_mw_o, state_o, mem_err_o,
        output stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage core: load-use, EX branch
// redirect and MEM wait with timeout, plus saturating perf counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    pipe_hazard_ctrl_if.slave  hz
);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] ERR      = 2'd2;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [7:0]       wait_q;
    logic [7:0]       wait_d;
    logic             err_q;
    logic             err_d;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    logic mem_stall;
    logic match_a;
    logic match_b;
    logic load_use;
    logic in_err;
    logic stall_all;
    logic br_flush;
    logic lu_stall;

    assign mem_stall = hz.mem_req_m & ~hz.mem_ready_i;

    assign match_a = hz.useA_d & (hz.AddrA_d == hz.AddrD_e);
    assign match_b = hz.useB_d & (hz.AddrB_d == hz.AddrD_e);

    // x0 is never a real producer, so it cannot create a load-use
    assign load_use = hz.is_load_e & hz.RegWEn_e
                    & (|hz.AddrD_e) & (match_a | match_b);

    assign in_err    = (state_q == ERR);
    assign stall_all = in_err | mem_stall;

    // Frozen DE/FD get re-evaluated once the full-pipe hold drops
    assign br_flush = ~stall_all & hz.br_taken_e;
    assign lu_stall = ~stall_all & ~hz.br_taken_e & load_use;

    assign hz.hold_pc_o  = stall_all | lu_stall;
    assign hz.hold_fd_o  = stall_all | lu_stall;
    assign hz.hold_de_o  = stall_all;
    assign hz.hold_em_o  = stall_all;
    assign hz.flush_fd_o = br_flush;
    assign hz.flush_de_o = br_flush | lu_stall;
    assign hz.flush_mw_o = stall_all;

    assign hz.state_o     = state_q;
    assign hz.mem_err_o   = err_q;
    assign hz.stall_cnt_o = stall_q;
    assign hz.flush_cnt_o = flush_q;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                    wait_d  = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    state_d = RUN;
                    wait_d  = 8'd0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = RUN;
                wait_d  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= RUN;
            wait_q  <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (hz.hold_pc_o && stall_q != CNT_MAX)
                stall_q <= stall_q + 1'b1;
            if (br_flush && flush_q != CNT_MAX)
                flush_q <= flush_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations plus a randomized run against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int TMO  = 4;
    localparam int CW   = 6;
    localparam int MAXC = (1 << CW) - 1;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) hz ();

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (TMO),
        .CNT_W       (CW)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .hz    (hz)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    // model: mode 0 run, 1 waiting, 2 error; run = consecutive stalls
    int m_mode  = 0;
    int m_run   = 0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    function automatic bit m_lu();
        int d;
        d = int'(hz.AddrD_e);
        if (!(hz.is_load_e && hz.RegWEn_e) || d == 0)
            return 0;
        return (hz.useA_d && int'(hz.AddrA_d) == d) ||
               (hz.useB_d && int'(hz.AddrB_d) == d);
    endfunction

    // {hold_pc, hold_fd, hold_de, hold_em, flush_fd, flush_de, flush_mw}
    function automatic logic [6:0] exp_ctl(int mode);
        bit ms;
        ms = hz.mem_req_m && !hz.mem_ready_i;
        if (mode == 2 || ms)   return 7'b1111001;
        if (hz.br_taken_e)     return 7'b0000110;
        if (m_lu())            return 7'b1100010;
        return 7'b0000000;
    endfunction

    task automatic m_reset();
        m_mode  = 0;
        m_run   = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    always @(posedge clk_i) begin
        logic [6:0] c;
        if (!rst_i) begin
            m_reset();
        end else begin
            c = exp_ctl(m_mode);
            if (c[6] && m_stall < MAXC) m_stall++;
            if (c[2] && m_flush < MAXC) m_flush++;
            if (m_mode != 2) begin
                if (hz.mem_req_m && !hz.mem_ready_i) begin
                    m_run++;
                    m_mode = (m_run >= TMO) ? 2 : 1;
                end else begin
                    m_run  = 0;
                    m_mode = 0;
                end
            end
        end
    end

    bit chk_en = 1'b1;

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("ctl", {hz.hold_pc_o, hz.hold_fd_o, hz.hold_de_o,
                        hz.hold_em_o, hz.flush_fd_o, hz.flush_de_o,
                        hz.flush_mw_o}, exp_ctl(m_mode));
            chk("state", hz.state_o, m_mode);
            chk("mem_err", hz.mem_err_o, m_mode == 2);
            chk("stall_cnt", hz.stall_cnt_o, m_stall);
            chk("flush_cnt", hz.flush_cnt_o, m_flush);
        end
    end

    task automatic clr();
        hz.RegWEn_e    = 0;
        hz.is_load_e   = 0;
        hz.AddrD_e     = 0;
        hz.AddrA_d     = 0;
        hz.AddrB_d     = 0;
        hz.useA_d      = 0;
        hz.useB_d      = 0;
        hz.br_taken_e  = 0;
        hz.mem_req_m   = 0;
        hz.mem_ready_i = 0;
    endtask

    task automatic set_lu(logic [4:0] d);
        hz.is_load_e = 1;
        hz.RegWEn_e  = 1;
        hz.AddrD_e   = d;
        hz.useB_d    = 1;
        hz.AddrB_d   = d;
    endtask

    task automatic settle();
        @(negedge clk_i);
        #1;
    endtask

    task automatic next();
        @(posedge clk_i);
        #1;
    endtask

    // asynchronous reset pulse, asserted between edges
    task automatic pulse_rst();
        @(posedge clk_i);
        #2;
        rst_i = 0;
        m_reset();
        #1;
        chk("arst_state", hz.state_o, 0);
        chk("arst_err", hz.mem_err_o, 0);
        chk("arst_stall", hz.stall_cnt_o, 0);
        chk("arst_flush", hz.flush_cnt_o, 0);
        settle();
        rst_i = 1;
        next();
    endtask

    initial begin
        clr();
        settle();
        chk("rst_state", hz.state_o, 0);
        chk("rst_hold", hz.hold_pc_o, 0);
        chk("rst_stall", hz.stall_cnt_o, 0);
        rst_i = 1;
        next();

        // load-use: one bubble
        set_lu(5'd5);
        settle();
        chk("lu_hold_pc", hz.hold_pc_o, 1);
        chk("lu_hold_fd", hz.hold_fd_o, 1);
        chk("lu_flush_de", hz.flush_de_o, 1);
        chk("lu_hold_de", hz.hold_de_o, 0);
        next();
        clr();
        settle();
        chk("lu_release", hz.hold_pc_o, 0);
        chk("lu_stall_cnt", hz.stall_cnt_o, 1);
        set_lu(5'd0);
        settle();
        chk("lu_x0", hz.hold_pc_o, 0);
        next();

        // branch beats load-use
        clr();
        set_lu(5'd5);
        hz.br_taken_e = 1;
        settle();
        chk("br_flush_fd", hz.flush_fd_o, 1);
        chk("br_flush_de", hz.flush_de_o, 1);
        chk("br_hold_pc", hz.hold_pc_o, 0);
        next();
        clr();
        settle();
        chk("br_flush_cnt", hz.flush_cnt_o, 1);
        chk("br_stall_cnt", hz.stall_cnt_o, 1);
        next();

        // three wait cycles then ready
        hz.mem_req_m = 1;
        settle();
        chk("mw1_hold_em", hz.hold_em_o, 1);
        chk("mw1_flush_mw", hz.flush_mw_o, 1);
        chk("mw1_state", hz.state_o, 0);
        next();
        settle();
        chk("mw2_state", hz.state_o, 1);
        next();
        settle();
        chk("mw3_state", hz.state_o, 1);
        chk("mw3_hold", hz.hold_pc_o, 1);
        next();
        hz.mem_ready_i = 1;
        settle();
        chk("mw_ready_hold", hz.hold_pc_o, 0);
        chk("mw_ready_state", hz.state_o, 1);
        next();
        clr();
        settle();
        chk("mw_done_state", hz.state_o, 0);
        chk("mw_stall_cnt", hz.stall_cnt_o, 4);
        next();

        // mem stall masks a branch until release
        hz.mem_req_m  = 1;
        hz.br_taken_e = 1;
        settle();
        chk("msb_hold", hz.hold_pc_o, 1);
        chk("msb_flush_fd", hz.flush_fd_o, 0);
        next();
        hz.mem_ready_i = 1;
        settle();
        chk("msb_rel_flush", hz.flush_fd_o, 1);
        chk("msb_rel_hold", hz.hold_pc_o, 0);
        next();
        clr();
        settle();
        chk("msb_flush_cnt", hz.flush_cnt_o, 2);
        chk("msb_stall_cnt", hz.stall_cnt_o, 5);
        next();

        // async reset in the middle of a wait
        hz.mem_req_m = 1;
        @(posedge clk_i);
        #1;
        chk("pre_arst_state", hz.state_o, 1);
        pulse_rst();
        clr();

        // timeout into ERR, which is sticky
        hz.mem_req_m = 1;
        repeat (TMO) @(posedge clk_i);
        settle();
        chk("tmo_state", hz.state_o, 2);
        chk("tmo_err", hz.mem_err_o, 1);
        hz.mem_ready_i = 1;
        settle();
        chk("err_hold", hz.hold_pc_o, 1);
        chk("err_flush_mw", hz.flush_mw_o, 1);
        clr();
        repeat (70) next();
        settle();
        chk("stall_sat", hz.stall_cnt_o, MAXC);
        chk("err_sticky", hz.state_o, 2);
        pulse_rst();

        // flush counter saturation
        hz.br_taken_e = 1;
        repeat (70) next();
        settle();
        chk("flush_sat", hz.flush_cnt_o, MAXC);
        clr();
        pulse_rst();

        // randomized segments, model-checked every cycle
        for (int seg = 0; seg < 12; seg++) begin
            int rdy_pct;
            int req_pct;
            rdy_pct = (seg % 3 == 0) ? 30 : ((seg % 3 == 1) ? 70 : 95);
            req_pct = 20 + 10 * (seg % 4);
            for (int c = 0; c < 150; c++) begin
                hz.RegWEn_e    = ($urandom_range(0, 99) < 80);
                hz.is_load_e   = ($urandom_range(0, 99) < 50);
                hz.AddrD_e     = 5'($urandom_range(0, 3));
                hz.AddrA_d     = 5'($urandom_range(0, 3));
                hz.AddrB_d     = 5'($urandom_range(0, 3));
                hz.useA_d      = $urandom_range(0, 1);
                hz.useB_d      = $urandom_range(0, 1);
                hz.br_taken_e  = ($urandom_range(0, 99) < 15);
                hz.mem_req_m   = ($urandom_range(0, 99) < req_pct);
                hz.mem_ready_i = ($urandom_range(0, 99) < rdy_pct);
                next();
            end
            pulse_rst();
        end

        clr();
        settle();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
